muxn_rr_reg: RTL
================

Name: muxn_rr_reg

Overview:
- Parametrised successor to the lab's 2:1 2-bit combinational mux.
- N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- Selection is either fixed (sel input) or round-robin arbitrated, chosen by the mode pin.
- A registered output stage gives 1-cycle latency; sits between ALU operand sources and the ALU input stage.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels (2..16).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel data valid.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  per-channel accept (one-hot or zero).
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  CH_W  channel index used when mode=0; CH_W = clog2(NCH).
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered data.
- out_chan  out  CH_W  source channel of out_data.
- out_ready  in  1  downstream accept.
- xfer_cnt  out  CNT_W  count of completed output transfers.

Behaviour:
- Reset (async, any time): out_valid=0, out_data=0, out_chan=0, rr pointer=0, xfer_cnt=0. Any in-flight word is dropped; in_ready=0 while rst is high.
- load = !out_valid || out_ready.
- Candidate selection:
  - mode=0: candidate = sel if sel<NCH and in_valid[sel]; otherwise no candidate.
  - mode=1: candidate = first i with in_valid[i]=1, scanning ptr, ptr+1, ... modulo NCH.
- in_ready[candidate] = load. All other in_ready bits are 0. in_ready is combinational and must not depend on in_ready.
- Input transfer (in_valid & in_ready on the candidate):
  - next edge: out_data <= channel data, out_chan <= candidate, out_valid <= 1.
  - latency 1 cycle.
- Output transfer (out_valid & out_ready):
  - xfer_cnt += 1, wrapping at 2^CNT_W.
  - If no new input transfers in the same cycle, out_valid <= 0.
- Simultaneous output and input transfer: the register reloads with the new word; out_valid stays 1. Full throughput is 1 word/cycle.
- Stall (out_valid=1, out_ready=0): all in_ready=0; out_data and out_chan hold stable.
- rr pointer:
  - updated only on an input transfer in mode=1: ptr <= candidate+1, wrapping NCH-1 -> 0.
  - unchanged in mode=0.
- mode/sel changes take effect on the next combinational evaluation; the output register contents are unaffected.
- NCH not a power of two: sel >= NCH is ignored (no grant); the pointer wraps at NCH, not 2^CH_W.

Optional Feature:
- Macro: MUXN_RR_PARITY_EN.
- Defined:
  - extra output out_par (1 bit) = even parity (XOR-reduce) of out_data, registered with out_data.
  - reset value 0.
- Undefined: out_par port absent; all other behaviour is identical.

Decomposition:
- Package muxn_pkg:
  - function clog2 (CH_W derivation).
  - localparam MODE_FIXED=1'b0, MODE_RR=1'b1.
- Sub-module rr_arbiter:
  - combinational NCH-bit round-robin priority pick.
  - inputs: req vector, ptr.
  - outputs: grant index, grant_valid.
  - instantiated once; the pointer register stays in the top.

Test Plan (WIDTH=8, NCH=4, CNT_W=16 unless stated):
- rst=1 mid-transfer with out_valid=1 -> out_valid, out_data, out_chan, xfer_cnt all 0 before the next clk edge; in_ready=0.
- mode=0, sel=2, in_valid=4'b1111, data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_chan=2; xfer_cnt increments each cycle.
- mode=1, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
- mode=1, in_valid=4'b1010 -> out_chan sequence 1,3,1,3.
- Stall: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0; out_data held; xfer_cnt unchanged.
- mode=0, sel=3 with NCH=3 -> in_ready=0 and out_valid remains 0.
- Exhaustive sweep in the style of the lab bench (WIDTH=2, NCH=2):
  - all a/b/sel combinations.
  - check out_data == in_data[sel] one cycle after each transfer.
  - print pass/fail per vector.

Source files
------------

// File: rtl/muxn_rr_reg_pkg.sv
// Shared helpers for the N-channel registered mux: channel-index width and mode encodings.
package muxn_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceil log2 with a floor of 1 so a 2-channel mux still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/muxn_rr_reg_if.sv
// Bus bundle for muxn_rr_reg; out_par exists only when MUXN_RR_PARITY_EN is defined.
interface muxn_rr_reg_if
  import muxn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = clog2(NCH);

  logic [NCH-1:0]            in_valid;
  logic [NCH-1:0][WIDTH-1:0] in_data;
  logic [NCH-1:0]            in_ready;
  logic                      mode;
  logic [CH_W-1:0]           sel;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [CH_W-1:0]           out_chan;
  logic                      out_ready;
  logic [CNT_W-1:0]          xfer_cnt;
`ifdef MUXN_RR_PARITY_EN
  logic                      out_par;
`endif

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_chan, xfer_cnt
`ifdef MUXN_RR_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input  in_ready, out_valid, out_data, out_chan, xfer_cnt
`ifdef MUXN_RR_PARITY_EN
    , input out_par
`endif
  );

endinterface

// File: rtl/muxn_rr_reg_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo NCH.
module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  int j;

  // Scan from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[CH_W'(j)]) begin
        gnt_idx = CH_W'(j);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// N-channel valid/ready mux, fixed-select or round-robin, with a 1-cycle output register.
// Optional MUXN_RR_PARITY_EN adds a registered even-parity bit of out_data.
module muxn_rr_reg
  import muxn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  muxn_rr_reg_if.slave bus
);

  localparam int CH_W = clog2(NCH);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] arb_idx, cand_idx;
  logic            arb_vld, cand_vld;
  logic            load, in_xfer, out_xfer;

  rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Out-of-range sel (non-power-of-two NCH) yields no candidate.
  always_comb begin
    cand_idx = arb_idx;
    cand_vld = arb_vld;
    if (bus.mode == MODE_FIXED) begin
      cand_idx = bus.sel;
      cand_vld = (int'(bus.sel) < NCH) && bus.in_valid[bus.sel];
    end
  end

  assign load     = !bus.out_valid || bus.out_ready;
  assign in_xfer  = !rst && load && cand_vld;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.in_ready = '0;
    if (in_xfer) bus.in_ready[cand_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      bus.xfer_cnt  <= '0;
      ptr           <= '0;
`ifdef MUXN_RR_PARITY_EN
      bus.out_par   <= 1'b0;
`endif
    end else begin
      if (in_xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.in_data[cand_idx];
        bus.out_chan  <= cand_idx;
`ifdef MUXN_RR_PARITY_EN
        bus.out_par   <= ^bus.in_data[cand_idx];
`endif
      end else if (out_xfer) begin
        bus.out_valid <= 1'b0;
      end
      if (out_xfer) bus.xfer_cnt <= bus.xfer_cnt + 1'b1;
      // Pointer moves past the winner so it gets lowest priority next time.
      if (in_xfer && bus.mode == MODE_RR)
        ptr <= (cand_idx == CH_W'(NCH - 1)) ? '0 : cand_idx + 1'b1;
    end
  end

endmodule
